// File: rtl/m_param_alu_if.sv
// Request/response port of m_param_alu: operation request in, registered result,
// flags and start/done handshake out.
interface m_param_alu_if #(parameter int WIDTH = 8);
  logic             iStart;
  logic [3:0]       iOp;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic [WIDTH-1:0] oResult;
  logic [3:0]       oFlags;
  logic             oBusy;
  logic             oDone;

  modport master (output iStart, iOp, iA, iB, input oResult, oFlags, oBusy, oDone);
  modport slave  (input iStart, iOp, iA, iB, output oResult, oFlags, oBusy, oDone);
endinterface

// File: rtl/m_param_alu.sv
// Registered WIDTH-bit ALU with persistent {S,Z,V,C} flags and start/done handshake.
// Define ALU_MUL_EN to compile in the multi-cycle shift-and-add multiplier (opcode 10).
module m_param_alu #(
  parameter int WIDTH = 8
) (
  input  logic          iClk,
  input  logic          iRst_n,
  m_param_alu_if.slave  bus
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_ADC = 4'd2, OP_SBB = 4'd3,
                         OP_AND = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6, OP_CMP = 4'd7,
                         OP_INC = 4'd8, OP_DEC = 4'd9;

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, MUL_RUN} state_t;
`else
  typedef enum logic {IDLE} state_t;
`endif

  state_t           stateQ, stateD;
  logic [WIDTH-1:0] resQ;
  logic [3:0]       flagsQ;
  logic             doneQ;

  logic [WIDTH-1:0] opB, logicRes, aluRes;
  logic [WIDTH:0]   sum;
  logic             cin, isSub, arith, legal, writeRes, aluC, aluV;
  logic [3:0]       aluFlags;
  logic             isMul, take, finish;

  // Subtraction runs as A + ~B + cin; the stored C is a borrow, so it is inverted on the way in and out.
  always_comb begin
    opB      = bus.iB;
    cin      = 1'b0;
    isSub    = 1'b0;
    arith    = 1'b1;
    legal    = 1'b1;
    writeRes = 1'b1;
    logicRes = '0;
    case (bus.iOp)
      OP_ADD: ;
      OP_SUB: begin opB = ~bus.iB; cin = 1'b1; isSub = 1'b1; end
      OP_ADC: cin = flagsQ[0];
      OP_SBB: begin opB = ~bus.iB; cin = ~flagsQ[0]; isSub = 1'b1; end
      OP_AND: begin arith = 1'b0; logicRes = bus.iA & bus.iB; end
      OP_OR:  begin arith = 1'b0; logicRes = bus.iA | bus.iB; end
      OP_XOR: begin arith = 1'b0; logicRes = bus.iA ^ bus.iB; end
      OP_CMP: begin opB = ~bus.iB; cin = 1'b1; isSub = 1'b1; writeRes = 1'b0; end
      OP_INC: opB = WIDTH'(1);
      OP_DEC: begin opB = ~WIDTH'(1); cin = 1'b1; isSub = 1'b1; end
      default: begin legal = 1'b0; writeRes = 1'b0; end
    endcase
    sum      = {1'b0, bus.iA} + {1'b0, opB} + {{WIDTH{1'b0}}, cin};
    aluRes   = arith ? sum[WIDTH-1:0] : logicRes;
    aluC     = arith & (sum[WIDTH] ^ isSub);
    aluV     = arith & (bus.iA[WIDTH-1] == opB[WIDTH-1]) & (sum[WIDTH-1] != bus.iA[WIDTH-1]);
    aluFlags = {aluRes[WIDTH-1], aluRes == '0, aluV, aluC};
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mulProd, mulCand, prodNext;
  logic [WIDTH-1:0]   mulPlier;
  logic [CW-1:0]      cnt;
  logic               hiNz, lastIter;
  logic [3:0]         mulFlags;

  always_comb begin
    prodNext = mulPlier[0] ? mulProd + mulCand : mulProd;
    hiNz     = prodNext[2*WIDTH-1:WIDTH] != '0;
    mulFlags = {prodNext[WIDTH-1], prodNext[WIDTH-1:0] == '0, hiNz, hiNz};
    lastIter = cnt == CW'(WIDTH - 1);
  end
  assign isMul = bus.iOp == OP_MUL;
`else
  assign isMul = 1'b0;
`endif

  always_comb begin
    stateD = stateQ;
    take   = 1'b0;
    finish = 1'b0;
    case (stateQ)
      IDLE: if (bus.iStart) begin
`ifdef ALU_MUL_EN
        if (isMul) stateD = MUL_RUN;
        else       take   = 1'b1;
`else
        take = 1'b1;
`endif
      end
`ifdef ALU_MUL_EN
      MUL_RUN: if (lastIter) begin
        stateD = IDLE;
        finish = 1'b1;
      end
`endif
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      stateQ <= IDLE;
      resQ   <= '0;
      flagsQ <= '0;
      doneQ  <= 1'b0;
`ifdef ALU_MUL_EN
      mulProd  <= '0;
      mulCand  <= '0;
      mulPlier <= '0;
      cnt      <= '0;
`endif
    end else begin
      stateQ <= stateD;
      doneQ  <= take | finish;
      if (take && legal) begin
        if (writeRes) resQ <= aluRes;
        flagsQ <= aluFlags;
      end
`ifdef ALU_MUL_EN
      if (stateQ == IDLE && bus.iStart && isMul) begin
        mulProd  <= '0;
        mulCand  <= {{WIDTH{1'b0}}, bus.iA};
        mulPlier <= bus.iB;
        cnt      <= '0;
      end else if (stateQ == MUL_RUN) begin
        mulProd  <= prodNext;
        mulCand  <= mulCand << 1;
        mulPlier <= mulPlier >> 1;
        cnt      <= cnt + CW'(1);
        if (finish) begin
          resQ   <= prodNext[WIDTH-1:0];
          flagsQ <= mulFlags;
          cnt    <= '0;
        end
      end
`endif
    end
  end

  assign bus.oResult = resQ;
  assign bus.oFlags  = flagsQ;
  assign bus.oDone   = doneQ;
`ifdef ALU_MUL_EN
  assign bus.oBusy   = stateQ == MUL_RUN;
`else
  assign bus.oBusy   = 1'b0;
`endif
endmodule

// File: tb/tb_m_param_alu.sv
// Directed bench for m_param_alu (WIDTH=8); multiplier vectors run when ALU_MUL_EN is defined.
module tb_m_param_alu;
  logic clk = 1'b0;
  logic rstN;
  int   nChecks = 0;
  int   nFail = 0;

  m_param_alu_if #(.WIDTH(8)) bus();
  m_param_alu #(.WIDTH(8)) dut (.iClk(clk), .iRst_n(rstN), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.iStart = 1'b1; bus.iOp = op; bus.iA = a; bus.iB = b;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
  endtask

  // One single-cycle op: result/flags/done right after the start edge, done low one edge later.
  task automatic expOp(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] expRes, input logic [3:0] expFlags);
    issue(op, a, b);
    chk({tag, " result"}, 32'(bus.oResult), 32'(expRes));
    chk({tag, " flags"},  32'(bus.oFlags),  32'(expFlags));
    chk({tag, " done"},   32'(bus.oDone),   32'd1);
    chk({tag, " busy"},   32'(bus.oBusy),   32'd0);
    @(posedge clk); #1;
    chk({tag, " done drop"}, 32'(bus.oDone), 32'd0);
  endtask

  initial begin
    rstN = 1'b0;
    bus.iStart = 1'b0; bus.iOp = 4'd0; bus.iA = 8'h00; bus.iB = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset result", 32'(bus.oResult), 32'd0);
    chk("reset flags",  32'(bus.oFlags),  32'd0);
    chk("reset busy",   32'(bus.oBusy),   32'd0);
    chk("reset done",   32'(bus.oDone),   32'd0);
    @(negedge clk) rstN = 1'b1;

    expOp("add ovf",   4'd0, 8'h7F, 8'h01, 8'h80, 4'b1010);
    expOp("sub borrow",4'd1, 8'h05, 8'h07, 8'hFE, 4'b1001);
    expOp("sbb",       4'd3, 8'h10, 8'h01, 8'h0E, 4'b0000);
    expOp("add carry", 4'd0, 8'hFF, 8'h01, 8'h00, 4'b0101);
    expOp("adc",       4'd2, 8'h00, 8'h00, 8'h01, 4'b0000);
    expOp("cmp eq",    4'd7, 8'h10, 8'h10, 8'h01, 4'b0100);
    expOp("illegal15", 4'd15,8'h33, 8'h44, 8'h01, 4'b0100);
    expOp("sub 0-1",   4'd1, 8'h00, 8'h01, 8'hFF, 4'b1001);
    expOp("and",       4'd4, 8'hF0, 8'h3C, 8'h30, 4'b0000);
    expOp("or",        4'd5, 8'hF0, 8'h0C, 8'hFC, 4'b1000);
    expOp("xor",       4'd6, 8'hAA, 8'hAA, 8'h00, 4'b0100);
    expOp("adc c0",    4'd2, 8'h01, 8'h01, 8'h02, 4'b0000);
    expOp("sbb c0",    4'd3, 8'h20, 8'h21, 8'hFF, 4'b1001);
    expOp("sbb c1",    4'd3, 8'h20, 8'h0F, 8'h10, 4'b0000);
    expOp("inc ovf",   4'd8, 8'h7F, 8'h00, 8'h80, 4'b1010);
    expOp("inc wrap",  4'd8, 8'hFF, 8'h00, 8'h00, 4'b0101);
    expOp("dec wrap",  4'd9, 8'h00, 8'h00, 8'hFF, 4'b1001);
    expOp("dec ovf",   4'd9, 8'h80, 8'h00, 8'h7F, 4'b0010);
    expOp("cmp lt",    4'd7, 8'h01, 8'h02, 8'h7F, 4'b1001);

    // Back-to-back starts keep done high
    @(negedge clk);
    bus.iStart = 1'b1; bus.iOp = 4'd0; bus.iA = 8'h01; bus.iB = 8'h01;
    @(posedge clk); #1;
    chk("b2b 1 result", 32'(bus.oResult), 32'h02);
    chk("b2b 1 done",   32'(bus.oDone),   32'd1);
    bus.iA = 8'h02; bus.iB = 8'h02;
    @(posedge clk); #1;
    chk("b2b 2 result", 32'(bus.oResult), 32'h04);
    chk("b2b 2 done",   32'(bus.oDone),   32'd1);
    bus.iStart = 1'b0;
    @(posedge clk); #1;
    chk("b2b done drop", 32'(bus.oDone), 32'd0);

`ifdef ALU_MUL_EN
    issue(4'd10, 8'h0C, 8'h0B);
    chk("mul busy 0", 32'(bus.oBusy), 32'd1);
    chk("mul done 0", 32'(bus.oDone), 32'd0);
    for (int i = 1; i < 8; i++) begin
      if (i == 3) begin
        bus.iStart = 1'b1; bus.iOp = 4'd0; bus.iA = 8'h11; bus.iB = 8'h22;
      end else begin
        bus.iStart = 1'b0;
      end
      @(posedge clk); #1;
      chk($sformatf("mul busy %0d", i), 32'(bus.oBusy), 32'd1);
      chk($sformatf("mul done %0d", i), 32'(bus.oDone), 32'd0);
    end
    bus.iStart = 1'b0;
    @(posedge clk); #1;
    chk("mul result", 32'(bus.oResult), 32'h84);
    chk("mul flags",  32'(bus.oFlags),  32'b1000);
    chk("mul done",   32'(bus.oDone),   32'd1);
    chk("mul busy end", 32'(bus.oBusy), 32'd0);
    @(posedge clk); #1;
    chk("mul ignored start", 32'(bus.oResult), 32'h84);
    chk("mul done drop", 32'(bus.oDone), 32'd0);

    issue(4'd10, 8'h10, 8'h10);
    repeat (7) @(posedge clk);
    #1;
    chk("mul hi done early", 32'(bus.oDone), 32'd0);
    @(posedge clk); #1;
    chk("mul hi result", 32'(bus.oResult), 32'h00);
    chk("mul hi flags",  32'(bus.oFlags),  32'b0111);
    chk("mul hi done",   32'(bus.oDone),   32'd1);

    // Reset during the third multiplier cycle aborts with no done
    issue(4'd10, 8'h03, 8'h05);
    repeat (2) @(posedge clk);
    @(negedge clk) rstN = 1'b0;
    @(posedge clk); #1;
    chk("rst mul result", 32'(bus.oResult), 32'd0);
    chk("rst mul flags",  32'(bus.oFlags),  32'd0);
    chk("rst mul busy",   32'(bus.oBusy),   32'd0);
    chk("rst mul done",   32'(bus.oDone),   32'd0);
    @(negedge clk) rstN = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rst no done %0d", i), 32'(bus.oDone), 32'd0);
    end
`else
    expOp("op10 illegal", 4'd10, 8'h0C, 8'h0B, 8'h04, 4'b0000);
    chk("op10 busy", 32'(bus.oBusy), 32'd0);
    @(negedge clk) rstN = 1'b0;
    @(posedge clk); #1;
    chk("rst result", 32'(bus.oResult), 32'd0);
    chk("rst flags",  32'(bus.oFlags),  32'd0);
    chk("rst done",   32'(bus.oDone),   32'd0);
    @(negedge clk) rstN = 1'b1;
`endif
    expOp("add after rst", 4'd0, 8'h01, 8'h02, 8'h03, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule

// File: doc/m_param_alu.md
# m_param_alu

Parametrised, registered arithmetic/logic unit for the SAP-2 datapath; successor to the fixed 8-bit combinational adder/subtractor. It adds carry-chained add/subtract, logic ops, increment/decrement and compare, and holds a persistent flag register. A start/done handshake lets an optional multi-cycle shift-and-add multiplier share the same port. The controller issues one operation per `iStart`. The block drives the accumulator write-back path and the flag inputs of the branch logic.

## Interface
- `WIDTH`, default 8: operand/result width; ≥ 2.
- `iClk` in 1: clock, rising edge.
- `iRst_n` in 1: reset, synchronous, active-low.
- `iStart` in 1: operation request; sampled only while `oBusy`=0.
- `iOp` in 4: opcode, captured with `iStart`.
- `iA` in `WIDTH`: operand A, captured with `iStart`.
- `iB` in `WIDTH`: operand B, captured with `iStart`.
- `oResult` out `WIDTH`: registered result.
- `oFlags` out 4: registered {S, Z, V, C}, bits [3:0].
- `oBusy` out 1: high while the multiplier runs.
- `oDone` out 1: one-cycle completion pulse.

## Operation
- **Opcodes:**
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 ADC: A+B+C.
  - 3 SBB: A−B−C.
  - 4 AND.
  - 5 OR.
  - 6 XOR.
  - 7 CMP: A−B, flags only; `oResult` holds its previous value.
  - 8 INC: A+1.
  - 9 DEC: A−1.
  - 10 MUL: `ALU_MUL_EN` only.
  - 11–15: illegal.
- **Arithmetic width:** internal sum is `WIDTH`+1 bits. Subtraction is A + ~B + 1, with the carry-in inverted for SBB.
- **C flag:**
  - Add ops: carry-out.
  - Subtract ops (SUB/SBB/CMP/DEC): borrow, i.e. C=1 when the unsigned minuend is less than the subtrahend (+borrow-in).
  - Logic ops: C=0.
- **V flag:** two's-complement overflow, computed from the operand MSBs and the result MSB. Logic ops: V=0.
- **S and Z:** S = result MSB; Z = (result == 0). Both update for every legal op. For CMP they are computed on the difference.
- **Illegal opcode:** result and flags unchanged; `oDone` still pulses.
- **Flag persistence:** flags change only on completion of a legal op. C carries between ops for ADC/SBB chaining.
- **State machine:**
  - IDLE: `iStart`=1 with a non-MUL op → compute, register result/flags, set `oDone`; stay in IDLE.
  - IDLE: `iStart`=1 with MUL → latch operands, clear accumulator, counter=0, go to MUL_RUN.
  - MUL_RUN: one multiplier bit per cycle, LSB first. After `WIDTH` iterations → write result/flags, set `oDone`, go to IDLE.
- **MUL result:** low `WIDTH` bits of the unsigned product.
  - S and Z from the low half.
  - C = V = 1 if the high half is nonzero, else 0.
- **Busy/start interaction:** `iStart` is ignored while `oBusy`=1; no queuing.

## Timing
- **Reset:** `iRst_n`=0 at a rising edge → `oResult`=0, `oFlags`=0, `oBusy`=0, `oDone`=0, state IDLE, counter=0. This applies at any time, including mid-MUL: the operation aborts and no `oDone` is produced.
- **Single-cycle ops:** `iStart` sampled at edge N → `oResult`/`oFlags` valid and `oDone`=1 after edge N. `oDone` drops after edge N+1 unless a new `iStart` is taken at N+1.
- **Back-to-back:** a start on every cycle is legal for non-MUL ops; `oDone` stays high continuously.
- **MUL:** `iStart` sampled at edge N → `oBusy`=1 after edges N … N+`WIDTH`−1. Result, flags and `oDone`=1 are valid after edge N+`WIDTH`, with `oBusy`=0 in the same cycle. A new `iStart` is accepted at edge N+`WIDTH`.
- **Operand stability:** operands need be stable only in the `iStart` cycle.

## Configuration
- **`ALU_MUL_EN` defined:** multiplier, MUL_RUN state, counter and `oBusy` logic are compiled in.
- **`ALU_MUL_EN` undefined:**
  - Opcode 10 is treated as illegal.
  - `oBusy` is tied to 0.
  - The state machine reduces to IDLE only; every op completes in one cycle.

## Test plan
- **ADD overflow:** WIDTH=8, ADD 0x7F+0x01 → `oResult`=0x80, {S,Z,V,C}=1010; `oDone` one cycle after start.
- **SUB borrow:** SUB 0x05−0x07 → 0xFE, flags 1001. Then SBB 0x10−0x01 → 0x0E, flags 0000.
- **Carry chain:** ADD 0xFF+0x01 → 0x00, flags 0101. Then ADC 0x00+0x00 → 0x01, flags 0000.
- **CMP / illegal:** CMP 0x10,0x10 → Z=1, `oResult` unchanged. Opcode 15 → result and flags unchanged, `oDone` pulses.
- **MUL (`ALU_MUL_EN`):**
  - 0x0C×0x0B → 0x84, flags 1000, `oBusy` high 8 cycles, `oDone` at cycle 8 after start.
  - 0x10×0x10 → 0x00, flags 0111.
  - `iStart` asserted mid-run is ignored.
- **Reset mid-MUL:** assert `iRst_n`=0 during MUL cycle 3 → all outputs 0 next cycle, no `oDone`. Then ADD 0x01+0x02 → 0x03.
